// File: rtl/alu_wb_pkg.sv
// Shared constants for the ALU write-back controller: op codes, FSM encoding, width defaults.
package alu_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: op, a, b -> y plus zero and signed-overflow flags.
module alu_core
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zf,
  output logic              of
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  // Overflow: operands that agree in sign (ADD) or differ (SUB) yet the result sign flips.
  always_comb begin
    y  = '0;
    of = 1'b0;
    case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_ADD: begin
        y  = sum;
        of = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_XOR: y = a ^ b;
      OP_NOR: y = ~(a | b);
      OP_SLL: y = a << b[4:0];
      OP_SUB: begin
        y  = diff;
        of = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_SLT: y = {{(DATA_W-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

  assign zf = (y == '0);

endmodule

// File: rtl/alu_wb_ctrl.sv
// Four-state read/execute/write-back controller around alu_core and an external register file.
// Optional: define ALU_WB_R0_GUARD_EN to suppress register-file writes when rd is 0.
module alu_wb_ctrl
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  input  logic [DATA_W-1:0] R_Data_A,
  input  logic [DATA_W-1:0] R_Data_B,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ZF,
  output logic              OF
);

  state_t state, next;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rs_q, rt_q, rd_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] result_q;
  logic              zf_q, of_q;

  logic [DATA_W-1:0] alu_y;
  logic              alu_zf, alu_of;
  logic              wr_ok;
  logic              accept;

  assign accept = (state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (start) next = ST_READ;
      ST_READ: next = ST_EXEC;
      ST_EXEC: next = ST_WB;
      ST_WB:   next = ST_IDLE;
      default: next = ST_IDLE;
    endcase
  end

  // Request fields are only captured on acceptance; starts while busy are dropped.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      op_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
    end else if (accept) begin
      op_q <= op;
      rs_q <= rs_addr;
      rt_q <= rt_addr;
      rd_q <= rd_addr;
    end
  end

  // Operands are frozen before WB, so rd aliasing rs/rt is harmless.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state == ST_READ) begin
      opa_q <= R_Data_A;
      opb_q <= R_Data_B;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      result_q <= '0;
      zf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else if (state == ST_EXEC) begin
      result_q <= alu_y;
      zf_q     <= alu_zf;
      of_q     <= alu_of;
    end
  end

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (opa_q),
    .b  (opb_q),
    .y  (alu_y),
    .zf (alu_zf),
    .of (alu_of)
  );

`ifdef ALU_WB_R0_GUARD_EN
  assign wr_ok = (rd_q != '0);
`else
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    Write_Reg = 1'b0;
    W_Addr    = '0;
    W_Data    = '0;
    R_Addr_A  = '0;
    R_Addr_B  = '0;
    case (state)
      ST_READ: begin
        busy     = 1'b1;
        R_Addr_A = rs_q;
        R_Addr_B = rt_q;
      end
      ST_EXEC: busy = 1'b1;
      ST_WB: begin
        busy      = 1'b1;
        done      = 1'b1;
        Write_Reg = wr_ok;
        W_Addr    = rd_q;
        W_Data    = result_q;
      end
      default: ;
    endcase
  end

  assign result = result_q;
  assign ZF     = zf_q;
  assign OF     = of_q;

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Randomized self-checking bench for alu_wb_ctrl with a register-file model and arithmetic reference ALU.
module tb_alu_wb_ctrl;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic [4:0]  R_Addr_A, R_Addr_B, W_Addr;
  logic [31:0] R_Data_A, R_Data_B, W_Data, result;
  logic        Write_Reg, busy, done, ZF, OF;

  logic [31:0] rf [32];
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  int checks = 0, failures = 0;
  logic        watch = 1'b0;
  int          we_seen = 0, done_seen = 0;

  logic [31:0] obs_wdata;
  logic [4:0]  obs_waddr;
  logic        obs_we, obs_zf, obs_of, obs_done;

  alu_wb_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .Reset(Reset), .start(start), .op(op),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .busy(busy), .done(done), .result(result), .ZF(ZF), .OF(OF)
  );

  always #5 clk = ~clk;

  assign R_Data_A = rf[R_Addr_A];
  assign R_Data_B = rf[R_Addr_B];

  always @(posedge clk) begin
    if (Write_Reg)  rf[W_Addr] <= W_Data;
    else if (ld_en) rf[ld_addr] <= ld_data;
  end

  always @(negedge clk) begin
    if (watch) begin
      if (Write_Reg) we_seen++;
      if (done)      done_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic: returns {of, zf, y}.
  function automatic logic [33:0] ref_alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r, ys;
    longint unsigned p;
    logic [31:0] y;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    y = '0;
    ovf = 1'b0;
    case (o)
      3'd0: y = a & b;
      3'd1: y = a | b;
      3'd2: begin r = sa + sb; y = r[31:0]; ys = $signed(y); ovf = (r != ys); end
      3'd3: y = a ^ b;
      3'd4: y = ~(a | b);
      3'd5: begin p = 64'(a) * (64'd1 << b[4:0]); y = p[31:0]; end
      3'd6: begin r = sa - sb; y = r[31:0]; ys = $signed(y); ovf = (r != ys); end
      default: y = (sa < sb) ? 32'd1 : 32'd0;
    endcase
    return {ovf, (y == 32'd0), y};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_we"}, 64'(Write_Reg), 64'(0));
    chk({tag, "_waddr"}, 64'(W_Addr), 64'(0));
    chk({tag, "_wdata"}, 64'(W_Data), 64'(0));
    chk({tag, "_raddr_a"}, 64'(R_Addr_A), 64'(0));
    chk({tag, "_raddr_b"}, 64'(R_Addr_B), 64'(0));
    chk({tag, "_result"}, 64'(result), 64'(0));
    chk({tag, "_zf"}, 64'(ZF), 64'(0));
    chk({tag, "_of"}, 64'(OF), 64'(0));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    logic [33:0] e;
    logic        exp_we;
    logic [31:0] old;
    int          k;
    e = ref_alu(o, rf[s], rf[t]);
    old = rf[d];
    exp_we = 1'b1;
`ifdef ALU_WB_R0_GUARD_EN
    exp_we = (d != 5'd0);
`endif
    start = 1'b1; op = o; rs_addr = s; rt_addr = t; rd_addr = d;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(7, 0));
    rs_addr = 5'($urandom_range(31, 0));
    rt_addr = 5'($urandom_range(31, 0));
    rd_addr = 5'($urandom_range(31, 0));
    chk("read_busy", 64'(busy), 64'(1));
    chk("read_raddr_a", 64'(R_Addr_A), 64'(s));
    chk("read_raddr_b", 64'(R_Addr_B), 64'(t));
    chk("read_done", 64'(done), 64'(0));
    k = 1;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 64'(k), 64'(3));
    obs_done = done; obs_we = Write_Reg; obs_waddr = W_Addr;
    obs_wdata = W_Data; obs_zf = ZF; obs_of = OF;
    chk("wb_done", 64'(done), 64'(1));
    chk("wb_we", 64'(Write_Reg), 64'(exp_we));
    chk("wb_waddr", 64'(W_Addr), 64'(d));
    chk("wb_wdata", 64'(W_Data), 64'(e[31:0]));
    chk("wb_zf", 64'(ZF), 64'(e[32]));
    chk("wb_of", 64'(OF), 64'(e[33]));
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_we", 64'(Write_Reg), 64'(0));
    chk("result_hold", 64'(result), 64'(e[31:0]));
    chk("rf_update", 64'(rf[d]), exp_we ? 64'(e[31:0]) : 64'(old));
  endtask

  initial begin
    int ndone;
    int k;
    logic [31:0] old12;
    logic        r0_we;

    // Preload the register file while reset is held; start is asserted to show it is ignored.
    start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_en = 1'b1;
      ld_addr = 5'(i);
      case (i)
        1: ld_data = 32'h7FFF_FFFF;
        2: ld_data = 32'h0000_0001;
        4, 5: ld_data = 32'h89AB_CDEF;
        7: ld_data = 32'hFFFF_FFFF;
        9: ld_data = 32'd31;
        default: ld_data = $urandom;
      endcase
    end
    @(negedge clk);
    ld_en = 1'b0;
    start = 1'b0;
    chk_all_zero("reset");
    Reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'(0));

    run_op(3'd2, 5'd1, 5'd2, 5'd3);
    chk("add_wdata", 64'(obs_wdata), 64'h8000_0000);
    chk("add_waddr", 64'(obs_waddr), 64'(3));
    chk("add_of", 64'(obs_of), 64'(1));
    chk("add_zf", 64'(obs_zf), 64'(0));

    run_op(3'd6, 5'd4, 5'd5, 5'd6);
    chk("sub_wdata", 64'(obs_wdata), 64'(0));
    chk("sub_zf", 64'(obs_zf), 64'(1));
    chk("sub_of", 64'(obs_of), 64'(0));

    run_op(3'd7, 5'd7, 5'd2, 5'd8);
    chk("slt_wdata", 64'(obs_wdata), 64'(1));
    run_op(3'd5, 5'd2, 5'd9, 5'd10);
    chk("sll_wdata", 64'(obs_wdata), 64'h8000_0000);

    // Start held for 10 cycles: cycle 1 is the first one start is seen in IDLE.
    start = 1'b1; op = 3'd2; rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd11;
    ndone = 0;
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("b2b_busy_c%0d", i), 64'(busy), 64'((i % 4) != 1));
      chk($sformatf("b2b_done_c%0d", i), 64'(done), 64'((i % 4) == 0));
      if (done) ndone++;
      @(negedge clk);
    end
    start = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (done) ndone++;
    chk("b2b_tail_latency", 64'(k), 64'(1));
    chk("b2b_ops", 64'(ndone), 64'(3));
    @(negedge clk);
    @(negedge clk);
    chk("b2b_no_extra", 64'(busy), 64'(0));

    // Abort during EXEC.
    old12 = rf[12];
    start = 1'b1; op = 3'd1; rs_addr = 5'd4; rt_addr = 5'd7; rd_addr = 5'd12;
    watch = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 Reset = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    repeat (4) @(negedge clk);
    watch = 1'b0;
    chk("abort_we_seen", 64'(we_seen), 64'(0));
    chk("abort_done_seen", 64'(done_seen), 64'(0));
    chk("abort_rf12", 64'(rf[12]), 64'(old12));
    chk("abort_busy", 64'(busy), 64'(0));
    run_op(3'd3, 5'd4, 5'd9, 5'd12);

    // rd = 0 write-back.
    r0_we = 1'b1;
`ifdef ALU_WB_R0_GUARD_EN
    r0_we = 1'b0;
`endif
    run_op(3'd2, 5'd2, 5'd9, 5'd0);
    chk("r0_done", 64'(obs_done), 64'(1));
    chk("r0_we", 64'(obs_we), 64'(r0_we));
    chk("r0_waddr", 64'(obs_waddr), 64'(0));

    for (int n = 0; n < 60; n++) begin
      run_op(3'($urandom_range(7, 0)), 5'($urandom_range(31, 0)),
             5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
      if ((n % 7) == 3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
